button_debouncer: RTL and testbench
===================================

# button_debouncer

Clean-up stage between the raw active-low PMOD push-buttons and the LED counter logic. It synchronises each button into the `clock` domain, rejects bounce and glitches with a per-channel stability counter, and presents a debounced level plus single-cycle press and release strobes. Downstream counters use `press` as a clock enable in the system clock domain, never as a clock or reset.

## Interface
- `WIDTH`, 2: number of independent button channels.
- `STABLE_CYCLES`, 120000: consecutive cycles a new input value must hold before it is accepted (10 ms at 12 MHz). Legal range ≥ 2.
- `clock` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `btn_n` input WIDTH: raw buttons, active-low (0 = pressed), asynchronous to `clock`.
- `level` output WIDTH: debounced state, active-high (1 = pressed).
- `press` output WIDTH: one-cycle strobe when `level[i]` goes 0→1.
- `release` output WIDTH: one-cycle strobe when `level[i]` goes 1→0.

## Operation
- Per channel, fully independent; there is no interaction between channels.
- Synchroniser: two flops `sync1`, `sync2` on `btn_n[i]`, both reset to 1 (released). Sample `s = ~sync2`.
- Counter `cnt`, width `$clog2(STABLE_CYCLES)`, resets to 0, never wraps (maximum value STABLE_CYCLES-1).
- FSM states, reset state RELEASED:
  - RELEASED: if `s`=1, go to PRESS_WAIT and set `cnt`=0; otherwise stay.
  - PRESS_WAIT: if `s`=0, go to RELEASED and set `cnt`=0 (glitch rejected, no strobe). Else if `cnt`=STABLE_CYCLES-1, go to PRESSED and set `level`=1, `press`=1, `cnt`=0. Else increment `cnt`.
  - PRESSED: if `s`=0, go to RELEASE_WAIT and set `cnt`=0.
  - RELEASE_WAIT: if `s`=1, go to PRESSED and set `cnt`=0. Else if `cnt`=STABLE_CYCLES-1, go to RELEASED and set `level`=0, `release`=1, `cnt`=0. Else increment `cnt`.
- `level` is 1 exactly in PRESSED and RELEASE_WAIT, and is registered.
- `press` and `release` are registered and high for exactly one cycle per accepted transition. They are never both high on one channel in the same cycle.
- Reset values: `level`=0, `press`=0, `release`=0, all FSMs RELEASED, all `cnt`=0, sync flops = 1.
- Button held low through reset deassertion: the press is debounced afresh from RELEASED, giving exactly one `press` strobe after full latency.
- Reset asserted mid-wait or mid-press: all outputs clear asynchronously. No `release` strobe is generated for the aborted press.

## Timing
- Edge numbering: the first rising edge that samples the new `btn_n` value is edge 1.
- `sync2` updates at edge 2. The FSM enters the WAIT state at edge 3.
- `level` and the strobe change at edge STABLE_CYCLES+3. The strobe drops at edge STABLE_CYCLES+4.
- Acceptance requires the new value held for STABLE_CYCLES+1 consecutive sampling edges. A pulse of STABLE_CYCLES edges or fewer is ignored.
- Minimum spacing between a `press` and the following `release` on one channel is STABLE_CYCLES+1 cycles.
- Throughput: at most one accepted transition per channel per STABLE_CYCLES+1 cycles. There is no backpressure; strobes are not queued.

## Test plan
- Reset values: assert `reset`, drive `btn_n`=2'b11, release reset → `level`=0, `press`=0, `release`=0 for 20 cycles.
- Clean press and release (STABLE_CYCLES=4): drop `btn_n[0]` to 0 before edge 1 → `level[0]`=1 and `press[0]`=1 at edge 7, `press[0]`=0 at edge 8. Raise it → `release[0]` one-cycle pulse 7 edges later. `level[1]` stays 0 throughout.
- Glitch boundary (STABLE_CYCLES=4): low pulse of 4 edges → no strobe, `level` stays 0. Low pulse of 5 edges → exactly one `press`, followed later by one `release`.
- Bounce: toggle `btn_n[1]` at 1–3-cycle intervals for 30 cycles, then hold 0 → exactly one `press[1]`, at edge 7 after the final falling transition.
- Simultaneous channels: drop both bits on the same edge → `press`=2'b11 on the same single cycle.
- Reset mid-operation: hold `btn_n[0]`=0 until `level[0]`=1, pulse `reset` for 1 cycle → `level` clears immediately with no `release`. With the button still held, one new `press[0]` appears 7 edges after reset deassertion.

Source files
------------

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer_if
//  Description : Button-side bundle for button_debouncer: raw active-low
//                buttons in, debounced level plus press/release strobes out.
//                `release` is a SystemVerilog keyword, so that strobe is
//                carried as `release_`.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] btn_n;     // raw buttons, active-low, asynchronous
    logic [WIDTH-1:0] level;     // debounced state, 1 = pressed
    logic [WIDTH-1:0] press;     // one-cycle strobe on level 0->1
    logic [WIDTH-1:0] release_;  // one-cycle strobe on level 1->0

    // Button source / consumer side
    modport master (
        output btn_n,
        input  level,
        input  press,
        input  release_
    );

    // Debouncer side
    modport slave (
        input  btn_n,
        output level,
        output press,
        output release_
    );
endinterface : button_debouncer_if
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Per-channel synchroniser + stability-counter debouncer for
//                active-low push-buttons. Produces a registered debounced
//                level and single-cycle press / release strobes, intended as
//                clock enables in the clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 120000
) (
    input  wire              clock,
    input  wire              reset,
    button_debouncer_if.slave bus
);

    // Counter only needs to reach STABLE_CYCLES-1; keep at least one bit so
    // the smallest legal setting still elaborates cleanly.
    localparam int c_CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic               r_sync1;
            logic               r_sync2;
            logic               w_s;
            state_t             r_state;
            state_t             w_state_next;
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_CNT_W-1:0] w_cnt_next;
            logic               r_level;
            logic               w_level_next;
            logic               r_press;
            logic               w_press_next;
            logic               r_release;
            logic               w_release_next;

            // Two-flop synchroniser; resets to the released (high) value so
            // a held button is debounced afresh after reset.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                end else begin
                    r_sync1 <= bus.btn_n[i];
                    r_sync2 <= r_sync1;
                end
            end

            // Synchronised sample, converted to active-high.
            assign w_s = ~r_sync2;

            // State, stability counter and registered outputs.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_state   <= ST_RELEASED;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_state   <= w_state_next;
                    r_cnt     <= w_cnt_next;
                    r_level   <= w_level_next;
                    r_press   <= w_press_next;
                    r_release <= w_release_next;
                end
            end

            // Next-state logic: any disagreement during a wait restarts from
            // the stable state, so only an unbroken run is accepted.
            always_comb begin
                w_state_next   = r_state;
                w_cnt_next     = r_cnt;
                w_press_next   = 1'b0;
                w_release_next = 1'b0;
                unique case (r_state)
                    ST_RELEASED: begin
                        if (w_s) begin
                            w_state_next = ST_PRESS_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            w_state_next = ST_RELEASED;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_next = ST_PRESSED;
                            w_cnt_next   = '0;
                            w_press_next = 1'b1;
                        end else begin
                            w_cnt_next   = r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_s) begin
                            w_state_next = ST_RELEASE_WAIT;
                            w_cnt_next   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            w_state_next = ST_PRESSED;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_next   = ST_RELEASED;
                            w_cnt_next     = '0;
                            w_release_next = 1'b1;
                        end else begin
                            w_cnt_next     = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = ST_RELEASED;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Debounced level is high exactly while pressed or waiting to
            // confirm a release; registered from the next state.
            assign w_level_next = (w_state_next == ST_PRESSED) ||
                                  (w_state_next == ST_RELEASE_WAIT);

            assign w_level[i]   = r_level;
            assign w_press[i]   = r_press;
            assign w_release[i] = r_release;
        end
    endgenerate

    assign bus.level    = w_level;
    assign bus.press    = w_press;
    assign bus.release_ = w_release;

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Scoreboard bench for button_debouncer (STABLE_CYCLES = 4).
//                Stimulus pushes the expected strobe (cycle, press, release,
//                level); a negedge monitor pops on every strobe it sees.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int c_WIDTH  = 2;
    localparam int c_STABLE = 4;
    localparam int c_LAT    = c_STABLE + 3;   // edge of strobe after edge 1

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] level;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    button_debouncer_if #(.WIDTH(c_WIDTH)) bus ();

    button_debouncer #(
        .WIDTH        (c_WIDTH),
        .STABLE_CYCLES(c_STABLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Edge counter: the value seen after edge k is k.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int at, input logic [1:0] p, input logic [1:0] r,
                        input logic [1:0] l);
        exp_t e;
        e.cyc = at; e.press = p; e.rel = r; e.level = l;
        sb.push_back(e);
    endtask

    task automatic check_idle(input string name, input logic [1:0] exp_level);
        n_checks++;
        if (bus.level !== exp_level || bus.press !== 2'b00 || bus.release_ !== 2'b00) begin
            n_fail++;
            $display("FAIL %s: got level=%b press=%b release=%b, expected level=%b press=00 release=00",
                     name, bus.level, bus.press, bus.release_, exp_level);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && ((bus.press | bus.release_) !== 2'b00)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: cyc=%0d press=%b release=%b level=%b, expected no strobe",
                         cyc, bus.press, bus.release_, bus.level);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || bus.press !== e.press || bus.release_ !== e.rel ||
                    bus.level !== e.level) begin
                    n_fail++;
                    $display("FAIL strobe: got cyc=%0d press=%b release=%b level=%b, expected cyc=%0d press=%b release=%b level=%b",
                             cyc, bus.press, bus.release_, bus.level,
                             e.cyc, e.press, e.rel, e.level);
                end
            end
        end
    end

    initial begin
        int durs[16];
        durs = '{2, 1, 3, 1, 2, 3, 1, 2, 1, 3, 2, 1, 3, 2, 1, 2};

        // Reset values
        bus.btn_n = 2'b11;
        reset     = 1'b1;
        tick(3);
        check_idle("in_reset", 2'b00);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            check_idle("after_reset", 2'b00);
        end
        tick(1);

        // Clean press and release on channel 0
        bus.btn_n[0] = 1'b0;
        push(cyc + c_LAT, 2'b01, 2'b00, 2'b01);
        tick(12);
        bus.btn_n[0] = 1'b1;
        push(cyc + c_LAT, 2'b00, 2'b01, 2'b00);
        tick(12);

        // Glitch of exactly STABLE_CYCLES edges: rejected
        bus.btn_n[0] = 1'b0;
        tick(c_STABLE);
        bus.btn_n[0] = 1'b1;
        tick(15);
        check_idle("glitch4_ignored", 2'b00);

        // STABLE_CYCLES+1 edges: accepted, then released
        bus.btn_n[0] = 1'b0;
        push(cyc + c_LAT, 2'b01, 2'b00, 2'b01);
        tick(c_STABLE + 1);
        bus.btn_n[0] = 1'b1;
        push(cyc + c_LAT, 2'b00, 2'b01, 2'b00);
        tick(12);

        // Bounce on channel 1, then settle low
        for (int i = 0; i < 16; i++) begin
            bus.btn_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(durs[i]);
        end
        bus.btn_n[1] = 1'b0;
        push(cyc + c_LAT, 2'b10, 2'b00, 2'b10);
        tick(12);
        bus.btn_n[1] = 1'b1;
        push(cyc + c_LAT, 2'b00, 2'b10, 2'b00);
        tick(12);

        // Both channels together
        bus.btn_n = 2'b00;
        push(cyc + c_LAT, 2'b11, 2'b00, 2'b11);
        tick(12);
        check_idle("both_held", 2'b11);
        bus.btn_n = 2'b11;
        push(cyc + c_LAT, 2'b00, 2'b11, 2'b00);
        tick(12);

        // Reset while pressed: immediate clear, no release, fresh press
        bus.btn_n[0] = 1'b0;
        push(cyc + c_LAT, 2'b01, 2'b00, 2'b01);
        tick(9);
        check_idle("held_before_reset", 2'b01);
        reset = 1'b1;
        #1;
        check_idle("async_reset_clear", 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        push(cyc + c_LAT, 2'b01, 2'b00, 2'b01);
        tick(12);
        bus.btn_n[0] = 1'b1;
        push(cyc + c_LAT, 2'b00, 2'b01, 2'b00);
        tick(12);

        // Every expected strobe must have been seen
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes: got %0d outstanding, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
